instr_encoder: RTL and testbench

Encoder counterpart to the Control_Unit decoder: assembles 32-bit RV64I instruction words from a class code plus register, function and immediate fields.
Covers exactly the four classes the Control_Unit decodes:
- R-type: opcode 0110011
- ld: opcode 0000011
- sd: opcode 0100011
- beq: opcode 1100011
Encoded words are buffered in a small FIFO with valid/ready handshakes on both sides. It feeds instruction memory initialisation or drives the datapath/control-unit bench as an instruction source.

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder.
//   Request side  : in_valid/in_ready plus the field set (in_type, rd, rs1, rs2,
//                   funct3, funct7, imm).
//   Delivery side : out_valid/out_ready, out_instr, plus enc_count and err status.
// The master modport is the request producer and word consumer; the slave
// modport is the encoder itself.
interface instr_encoder_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_type;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [12:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] enc_count;
  logic             err;

  modport master (
    output in_valid, in_type, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, enc_count, err
  );

  modport slave (
    input  in_valid, in_type, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, enc_count, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: builds 32-bit RV64I words for the R-type, ld, sd and beq
// classes and queues them in a DEPTH-entry FIFO.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; flushes the FIFO and clears status
//   bus    : instr_encoder_if.slave
//            in_valid/in_ready/in_type/rd/rs1/rs2/funct3/funct7/imm  request
//            out_valid/out_ready/out_instr                           delivery
//            enc_count : words delivered (wraps at 2^CNT_W)
//            err       : one-cycle pulse after an illegal request is consumed
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_encoder_if.slave      bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpLd  = 7'b0000011;
  localparam logic [6:0] OpSd  = 7'b0100011;
  localparam logic [6:0] OpBeq = 7'b1100011;

  logic [31:0]     r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic [31:0]     r_last;
  logic [CNT_W-1:0] r_enc_count;
  logic            r_err;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Field assembly for each class; fields a class does not use are ignored.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (bus.in_type)
      2'b00: begin
        w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OpR};
      end
      2'b01: begin
        w_word  = {bus.imm[11:0], bus.rs1, 3'b011, bus.rd, OpLd};
        // 12-bit signed range: the 13th bit must be a sign extension.
        w_legal = (bus.imm[12] == bus.imm[11]);
      end
      2'b10: begin
        w_word  = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b011, bus.imm[4:0], OpSd};
        w_legal = (bus.imm[12] == bus.imm[11]);
      end
      default: begin
        w_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                   bus.imm[4:1], bus.imm[11], OpBeq};
        // Branch offsets are in halfwords; an odd byte offset is unencodable.
        w_legal = ~bus.imm[0];
      end
    endcase
  end

  assign w_full   = (r_count == FullCount);
  assign w_empty  = (r_count == '0);
  // Acceptance only looks at current fullness, so a full FIFO refuses even
  // when the head is popped on the same edge.
  assign w_accept = bus.in_valid & ~w_full;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = ~w_empty & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_enc_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_legal;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_last      <= r_mem[r_rd_ptr];
        r_enc_count <= r_enc_count + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  // When empty, show the last word that left (or 0 after reset) rather than
  // whatever stale entry sits under the read pointer.
  assign bus.out_instr = w_empty ? r_last : r_mem[r_rd_ptr];
  assign bus.enc_count = r_enc_count;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases for each instruction
// class, backpressure, illegal requests and mid-stream reset, then random
// traffic compared against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk;
  logic reset;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  instr_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] mq[$];
  logic [31:0] m_last = 32'h0;
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Encoding computed from the field layout with integer arithmetic.
  function automatic void ref_enc(input logic [1:0] t, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [12:0] imm,
                                  output logic [31:0] w, output bit legal);
    int s;
    int u;
    s = (int'(imm) >= 4096) ? int'(imm) - 8192 : int'(imm);
    w = 32'h0;
    legal = 1'b1;
    case (t)
      2'd0: begin
        w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
          | (32'(rd) << 7) | 32'h33;
      end
      2'd1: begin
        legal = (s >= -2048) && (s <= 2047);
        u = s & 'hFFF;
        w = (32'(u) << 20) | (32'(rs1) << 15) | (32'd3 << 12) | (32'(rd) << 7) | 32'h03;
      end
      2'd2: begin
        legal = (s >= -2048) && (s <= 2047);
        u = s & 'hFFF;
        w = (32'(u >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd3 << 12)
          | (32'(u & 31) << 7) | 32'h23;
      end
      default: begin
        legal = (s % 2) == 0;
        u = s & 'h1FFF;
        w = (32'((u >> 12) & 1) << 31) | (32'((u >> 5) & 63) << 25) | (32'(rs2) << 20)
          | (32'(rs1) << 15) | (32'((u >> 1) & 15) << 8) | (32'((u >> 11) & 1) << 7)
          | 32'h63;
      end
    endcase
  endfunction

  task automatic set_req(input logic [1:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [12:0] imm);
    bus.in_type = t;
    bus.rd      = rd;
    bus.rs1     = rs1;
    bus.rs2     = rs2;
    bus.funct3  = f3;
    bus.funct7  = f7;
    bus.imm     = imm;
  endtask

  // One clock: predict from current inputs, advance, then compare every output.
  task automatic cycle(output bit acc);
    logic [31:0] w;
    bit legal;
    bit pop;
    ref_enc(bus.in_type, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.funct7, bus.imm, w, legal);
    acc = !reset && bus.in_valid && (mq.size() < DEPTH);
    pop = !reset && bus.out_ready && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_last = 32'h0;
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      if (pop) begin
        m_last = mq.pop_front();
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
      if (acc && legal) mq.push_back(w);
      m_err = acc && !legal;
    end
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    check("out_instr", bus.out_instr, (mq.size() > 0) ? mq[0] : m_last);
    check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check("enc_count", 32'(bus.enc_count), 32'(m_cnt));
    check("err", 32'(bus.err), 32'(m_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int base;
    logic [31:0] w_exp;
    bit legal;

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    cycle(acc);
    cycle(acc);
    reset = 1'b0;
    cycle(acc);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);

    // add x3,x1,x2
    bus.out_ready = 1'b1;
    set_req(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("add_word", bus.out_instr, 32'h002081B3);
    cycle(acc);
    check("add_count", 32'(bus.enc_count), 32'd1);

    // ld x5,8(x6)
    set_req(2'd1, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 13'd8);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("ld_word", bus.out_instr, 32'h00833283);
    cycle(acc);

    // sd x7,16(x2)
    set_req(2'd2, 5'd0, 5'd2, 5'd7, 3'd0, 7'd0, 13'd16);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("sd_word", bus.out_instr, 32'h00713823);
    cycle(acc);

    // beq x1,x2,-8
    set_req(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("beq_word", bus.out_instr, 32'hFE208CE3);
    cycle(acc);

    // Backpressure: five requests against a four-entry FIFO.
    base = m_cnt;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(2'd0, 5'(i + 1), 5'(i), 5'(i + 2), 3'(i), 7'd0, 13'd0);
      bus.in_valid = 1'b1;
      cycle(acc);
      check("bp_accept", 32'(acc), 32'd1);
    end
    check("bp_full", 32'(bus.in_ready), 32'd0);
    set_req(2'd1, 5'd9, 5'd10, 5'd0, 3'd0, 7'd0, 13'd100);
    cycle(acc);
    cycle(acc);
    check("bp_held", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(acc);
    check("bp_fifth_taken", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(acc);
    check("bp_drained", 32'(mq.size()), 32'd0);
    check("bp_count", 32'(bus.enc_count), 32'(base + 5));
    check("bp_valid_low", 32'(bus.out_valid), 32'd0);

    // Illegal beq (odd offset).
    base = m_cnt;
    set_req(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd5);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("beq_odd_err", 32'(bus.err), 32'd1);
    check("beq_odd_noq", 32'(bus.out_valid), 32'd0);
    cycle(acc);
    check("beq_odd_pulse", 32'(bus.err), 32'd0);
    check("beq_odd_cnt", 32'(bus.enc_count), 32'(base));

    // Illegal ld (offset 2048).
    set_req(2'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 13'd2048);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("ld_range_err", 32'(bus.err), 32'd1);
    check("ld_range_noq", 32'(bus.out_valid), 32'd0);
    cycle(acc);
    check("ld_range_pulse", 32'(bus.err), 32'd0);

    // Legal ld x1,-2048(x2) after the errors.
    set_req(2'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 13'h1800);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid = 1'b0;
    check("ld_min_word", bus.out_instr, 32'h80013083);
    check("ld_min_noerr", 32'(bus.err), 32'd0);
    cycle(acc);

    // Reset with three words queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(2'd0, 5'(i + 10), 5'(i), 5'(i), 3'd0, 7'h20, 13'd0);
      bus.in_valid = 1'b1;
      cycle(acc);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cycle(acc);
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus.enc_count), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    set_req(2'd2, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 13'd24);
    ref_enc(2'd2, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 13'd24, w_exp, legal);
    bus.in_valid = 1'b1;
    cycle(acc);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("mid_rst_first", bus.out_instr, w_exp);
    cycle(acc);
    check("mid_rst_popped", 32'(bus.enc_count), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_req(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), 13'($urandom));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      reset         = ($urandom_range(0, 63) == 0);
      cycle(acc);
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle(acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
